// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and decode constants for the multiply/divide unit.
//            Provides the RISC-V funct3 operation encoding, FSM state type
//            and per-operation lookup masks (operand signedness, result
//            selection).
// Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // RISC-V M-extension funct3 codes
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_e;

    // Lookup masks indexed by funct3 (bit i describes op code i).
    // rs1 treated as signed: MUL, MULH, MULHSU, DIV, REM.
    // MUL's low half is sign-agnostic; treating it as signed*signed is exact.
    localparam logic [7:0] c_MASK_A_SIGNED = 8'b0101_0111;
    // rs2 treated as signed: MUL, MULH, DIV, REM.
    localparam logic [7:0] c_MASK_B_SIGNED = 8'b0101_0011;
    // Multiply ops returning the upper half of the product: MULH/MULHSU/MULHU.
    localparam logic [7:0] c_MASK_SEL_HI   = 8'b0000_1110;
    // Divide ops returning the remainder rather than the quotient: REM/REMU.
    localparam logic [7:0] c_MASK_SEL_REM  = 8'b1100_0000;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/restoring_div_step.sv
`default_nettype none
// ============================================================================
// Module   : restoring_div_step
// Purpose  : One combinational restoring-division iteration. The dividend
//            is held in the quotient register and shifted out MSB-first into
//            the partial remainder while quotient bits shift in at the LSB.
// Ports    : i_rem  partial remainder (always < divisor)
//            i_quo  quotient / remaining dividend bits
//            i_div  divisor magnitude
//            o_rem  next partial remainder
//            o_quo  next quotient / remaining dividend bits
// Revision : 1.0  initial release
// ============================================================================
module restoring_div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_rem,
    input  logic [N-1:0] i_quo,
    input  logic [N-1:0] i_div,
    output logic [N-1:0] o_rem,
    output logic [N-1:0] o_quo
);

    // Shifted remainder needs one extra bit: i_rem < i_div <= 2^N-1.
    logic [N:0] w_shift;
    logic       w_fits;

    always_comb begin
        w_shift = {i_rem, i_quo[N-1]};
        w_fits  = (w_shift >= {1'b0, i_div});
        // When the trial subtraction succeeds the true difference is below
        // the divisor, so the low N bits of the wrapped difference are exact.
        o_rem   = w_fits ? (w_shift[N-1:0] - i_div) : w_shift[N-1:0];
        o_quo   = {i_quo[N-2:0], w_fits};
    end

endmodule : restoring_div_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle RISC-V M-extension multiply/divide unit. A radix-2
//            shift-add multiplier and restoring divider share one pair of
//            N-bit working registers and run one iteration per clock on
//            operand magnitudes; signs are re-applied when the result is
//            registered.
// Ports    : clk, rst         clock, asynchronous active-high reset
//            flush            abandon current operation / discard result
//            in_valid/in_ready, op, a, b     request handshake and operands
//            out_valid/out_ready, result     response handshake and result
//            busy             unit is not idle
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
);

    localparam int              CW        = $clog2(N) + 1;
    localparam logic [N-1:0]    c_INT_MIN = {1'b1, {(N-1){1'b0}}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    muldiv_state_e  r_state;
    muldiv_state_e  w_state_next;
    logic [2:0]     r_op;
    logic           r_neg_res;   // negate product / quotient
    logic           r_neg_rem;   // negate remainder (dividend was negative)
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_hi;        // product high half / partial remainder
    logic [N-1:0]   r_lo;        // multiplier / dividend->quotient / special result
    logic [N-1:0]   r_bmag;      // multiplicand / divisor magnitude
    logic [N-1:0]   r_result;
    logic           r_out_valid;

    // Control strobes from the output decode
    logic           w_accept;
    logic           w_iter;
    logic           w_load_result;
    logic           w_drain;

    // ------------------------------------------------------------------
    // Operand decode at accept
    // ------------------------------------------------------------------
    logic           w_a_neg;
    logic           w_b_neg;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic           w_div_zero;
    logic           w_div_ovf;
    logic           w_special;
    logic [N-1:0]   w_special_val;

    always_comb begin
        w_a_neg    = c_MASK_A_SIGNED[op] & a[N-1];
        w_b_neg    = c_MASK_B_SIGNED[op] & b[N-1];
        w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
        w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
        w_div_zero = op[2] && (b == '0);
        w_div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == c_INT_MIN) && (&b);
        w_special  = w_div_zero || w_div_ovf;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (w_div_zero) begin
            w_special_val = op[1] ? a : '1;
        end else begin
            w_special_val = op[1] ? '0 : a;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [N:0]     w_mul_sum;
    logic [N-1:0]   w_div_rem;
    logic [N-1:0]   w_div_quo;

    // Carry of the partial-product add is kept and shifted into r_hi.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_bmag} : {(N+1){1'b0}});

    restoring_div_step #(
        .N (N)
    ) u_div_step (
        .i_rem (r_hi),
        .i_quo (r_lo),
        .i_div (r_bmag),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );

    // ------------------------------------------------------------------
    // Sign fixup and result selection
    // ------------------------------------------------------------------
    logic [2*N-1:0] w_prod_fx;
    logic [N-1:0]   w_quo_fx;
    logic [N-1:0]   w_rem_fx;
    logic [N-1:0]   w_result_next;

    always_comb begin
        w_prod_fx = r_neg_res ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
        w_quo_fx  = r_neg_res ? (~r_lo + 1'b1) : r_lo;
        w_rem_fx  = r_neg_rem ? (~r_hi + 1'b1) : r_hi;
        if (r_state == S_DONE) begin
            // Special-case result was parked in r_lo at accept
            w_result_next = r_lo;
        end else if (r_op[2]) begin
            w_result_next = c_MASK_SEL_REM[r_op] ? w_rem_fx : w_quo_fx;
        end else begin
            w_result_next = c_MASK_SEL_HI[r_op] ? w_prod_fx[2*N-1:N] : w_prod_fx[N-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                // Special cases skip the iterations; out_valid rises on the
                // first DONE cycle so the result appears one edge later.
                if (w_accept) w_state_next = w_special ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == '0) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (w_drain) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (flush) w_state_next = S_IDLE;
    end

    // ------------------------------------------------------------------
    // FSM: output / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready      = (r_state == S_IDLE) && !flush;
        busy          = (r_state != S_IDLE);
        w_accept      = in_valid && in_ready;
        w_iter        = (r_state == S_CALC) && (r_cnt != '0);
        w_load_result = !flush &&
                        (((r_state == S_CALC) && (r_cnt == '0)) ||
                         ((r_state == S_DONE) && !r_out_valid));
        w_drain       = (r_state == S_DONE) && r_out_valid && out_ready;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_bmag    <= '0;
        end else if (w_accept) begin
            r_op      <= op;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= CW'(N);
            r_hi      <= '0;
            r_lo      <= w_special ? w_special_val : w_a_mag;
            r_bmag    <= w_b_mag;
        end else if (w_iter) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_op[2]) begin
                r_hi <= w_div_rem;
                r_lo <= w_div_quo;
            end else begin
                r_hi <= w_mul_sum[N:1];
                r_lo <= {w_mul_sum[0], r_lo[N-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load_result) r_result <= w_result_next;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load_result) begin
                r_out_valid <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign result    = r_result;
    assign out_valid = r_out_valid;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit (N=32): functional
//            results for all ops, latency, special cases, backpressure,
//            flush and asynchronous reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         busy;

    int           total = 0;
    int           bad   = 0;
    logic [N-1:0] last_res;

    always #5 clk = ~clk;

    muldiv_unit #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then scramble the inputs to show they
    // are only sampled on accept.
    task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op       = ~o;
        a        = ~x;
        b        = ~y;
    endtask

    task automatic wait_valid(output int edges, output int busy_low);
        edges    = 0;
        busy_low = 0;
        while (out_valid !== 1'b1 && edges < 100) begin
            if (busy !== 1'b1) busy_low++;
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input logic [N-1:0] exp, input int exp_lat);
        int edges;
        int bl;
        issue(o, x, y);
        wait_valid(edges, bl);
        check({tag, " latency"}, N'(edges), N'(exp_lat));
        check({tag, " busy"},    N'(bl), '0);
        check({tag, " result"},  result, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drained"}, N'(out_valid), '0);
        last_res = exp;
    endtask

    initial begin
        int edges;
        int bl;
        int errs;
        int pulses;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'b000;
        a         = '0;
        b         = '0;
        last_res  = '0;

        // Reset state
        #12;
        check("rst out_valid", N'(out_valid), '0);
        check("rst busy",      N'(busy), '0);
        check("rst result",    result, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst in_ready", N'(in_ready), 32'd1);

        // Multiply
        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        // Divide
        run_op("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu", 3'b101, 32'd100,       32'd7, 32'd14,        33);
        run_op("remu", 3'b111, 32'd100,       32'd7, 32'd2,         33);

        // Special cases
        run_op("div0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu0",   3'b111, 32'd5,         32'd0,         32'd5,         1);
        run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Backpressure
        issue(3'b101, 32'd100, 32'd7);
        wait_valid(edges, bl);
        check("bp result", result, 32'd14);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) errs++;
        end
        check("bp hold", N'(errs), '0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp out_valid cleared", N'(out_valid), '0);
        check("bp in_ready",          N'(in_ready), 32'd1);
        check("bp busy",              N'(busy), '0);
        run_op("b2b mul", 3'b000, 32'd3, 32'd5, 32'd15, 33);

        // Flush during CALC iteration 10
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) tick();
        check("flush busy before", N'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy",      N'(busy), '0);
        check("flush out_valid", N'(out_valid), '0);
        check("flush result",    result, last_res);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        check("flush no pulse", N'(pulses), '0);
        run_op("post-flush remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);

        // Flush beats in_valid
        op       = 3'b000;
        a        = 32'd2;
        b        = 32'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush in_ready", N'(in_ready), '0);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush no accept", N'(busy), '0);

        // Asynchronous reset mid-CALC
        issue(3'b100, 32'd1000, 32'd3);
        repeat (5) tick();
        check("arst busy before", N'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst out_valid", N'(out_valid), '0);
        check("arst busy",      N'(busy), '0);
        check("arst result",    result, '0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("arst in_ready", N'(in_ready), 32'd1);
        run_op("post-rst div", 3'b100, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
